// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap sequencer.
//   N_TAPS  : taps in the FIR core; also the load and flush length in cycles
//   BW_IN   : coefficient / sample width (signed)
//   BW_OUT  : core output width (low bits of the core sum)
//   CNT_W   : load/flush counter width; 2**CNT_W must exceed N_TAPS
//   state_e : sequencer FSM encoding, exposed on the top-level debug port
package fir_pkg;

  localparam int N_TAPS = 5;
  localparam int BW_IN  = 6;
  localparam int BW_OUT = 8;
  localparam int CNT_W  = 3;

  // Counter value that starts both the load and the flush countdowns.
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

  // The core shifts every cycle; in these states the shifted-in value is a
  // real sample (or a flush zero) whose output must be tagged valid.
  function automatic logic is_fed(state_e s);
    return (s == ST_RUN) || (s == ST_FLUSH);
  endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Bus bundle between host/sample source, sequencer and FIR core.
//   cfg_we/cfg_addr/cfg_data : coefficient bank write port (IDLE only)
//   start/stop               : run control pulses
//   s_valid/s_data/s_ready   : input sample stream
//   fir_rst/fir_x/fir_y      : FIR core connection
//   m_valid/m_data           : tagged filter output
//   busy/underrun            : status
// Sample handshake: a sample transfers on a rising clk edge where s_valid and
// s_ready are both high. s_ready is high for every RUN cycle and does not
// depend on s_valid. The core cannot stall, so a RUN cycle with s_valid low
// still shifts a zero into the core and sets the sticky underrun flag.
// m_valid has no back-pressure: each beat is present for exactly one cycle.
interface fir_tap_sequencer_if;
  import fir_pkg::*;

  logic                     cfg_we;
  logic [CNT_W-1:0]         cfg_addr;
  logic signed [BW_IN-1:0]  cfg_data;
  logic                     start;
  logic                     stop;
  logic                     s_valid;
  logic signed [BW_IN-1:0]  s_data;
  logic                     s_ready;
  logic                     fir_rst;
  logic signed [BW_IN-1:0]  fir_x;
  logic [BW_OUT-1:0]        fir_y;
  logic                     m_valid;
  logic [BW_OUT-1:0]        m_data;
  logic                     busy;
  logic                     underrun;

  // Sequencer side.
  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, stop, s_valid, s_data, fir_y,
    output s_ready, fir_rst, fir_x, m_valid, m_data, busy, underrun
  );

  // Host / sample source / core side.
  modport master (
    output cfg_we, cfg_addr, cfg_data, start, stop, s_valid, s_data, fir_y,
    input  s_ready, fir_rst, fir_x, m_valid, m_data, busy, underrun
  );

endinterface

// File: rtl/fir_coef_bank.sv
// Coefficient register file: N_TAPS x BW_IN signed entries.
//   clk, reset : clock, asynchronous active-high reset (entries clear to 0)
//   wr_en      : write strobe; addresses >= N_TAPS are dropped
//   wr_addr    : write tap index
//   wr_data    : write coefficient
//   rd_addr    : combinational read index (out-of-range reads return 0)
//   rd_data    : coefficient at rd_addr
module fir_coef_bank
  import fir_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [CNT_W-1:0]        wr_addr,
  input  logic signed [BW_IN-1:0] wr_data,
  input  logic [CNT_W-1:0]        rd_addr,
  output logic signed [BW_IN-1:0] rd_data
);

  logic signed [BW_IN-1:0] bank_q [N_TAPS];
  logic signed [BW_IN-1:0] bank_d [N_TAPS];

  // Decoding per entry means an address past the last tap matches nothing,
  // so such writes vanish without a separate range check.
  always_comb begin
    for (int i = 0; i < N_TAPS; i++) begin
      bank_d[i] = bank_q[i];
      if (wr_en && (wr_addr == CNT_W'(i))) begin
        bank_d[i] = wr_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      if (rd_addr == CNT_W'(i)) begin
        rd_data = bank_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_TAPS; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_TAPS; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Controller for the 5-tap shift-loaded FIR core.
// Holds the coefficient bank, resets and serially loads the core (highest tap
// first), streams samples into it, tags each core output beat that belongs to
// a fed sample, and flushes the delay line with zeros on stop.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : fir_tap_sequencer_if.slave (cfg, control, sample stream,
//                core connection, output stream, status)
//   dbg_state  : current FSM state
module fir_tap_sequencer
  import fir_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  fir_tap_sequencer_if.slave    bus,
  output state_e                dbg_state
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    v1_q, v1_d;
  logic                    v2_q, v2_d;
  logic                    underrun_q, underrun_d;
  logic                    s_ready_q, s_ready_d;
  logic                    busy_q, busy_d;
  logic                    fed;
  logic signed [BW_IN-1:0] fir_x_c;
  logic signed [BW_IN-1:0] bank_rd;
  logic                    bank_we;

  // Writes only land in IDLE, so a running load never sees a changing bank.
  assign bank_we = bus.cfg_we && (state_q == ST_IDLE);

  fir_coef_bank u_coef_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bank_we),
    .wr_addr (bus.cfg_addr),
    .wr_data (bus.cfg_data),
    .rd_addr (cnt_q),
    .rd_data (bank_rd)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    underrun_d = underrun_q;
    fir_x_c    = '0;
    fed        = is_fed(state_q);

    case (state_q)
      ST_IDLE: begin
        // start has priority; stop alone means nothing here.
        if (bus.start) begin
          state_d    = ST_CLR;
          underrun_d = 1'b0;
        end
      end

      ST_CLR: begin
        state_d = ST_LOAD;
        cnt_d   = LAST_TAP;
      end

      ST_LOAD: begin
        // Counting down shifts the highest tap in first, so after N_TAPS
        // shifts core tap k holds bank[k].
        fir_x_c = bank_rd;
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (bus.s_valid) begin
          fir_x_c = bus.s_data;
        end else begin
          underrun_d = 1'b1;
        end
        // The sample presented alongside stop is still taken.
        if (bus.stop) begin
          state_d = ST_FLUSH;
          cnt_d   = LAST_TAP;
        end
      end

      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A sample shifted in at edge e is summed by the core at e+1, so the
    // valid tag needs two stages to line up with fir_y.
    v1_d      = fed;
    v2_d      = v1_q;
    s_ready_d = (state_d == ST_RUN);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      underrun_q <= 1'b0;
      s_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      underrun_q <= underrun_d;
      s_ready_q  <= s_ready_d;
      busy_q     <= busy_d;
    end
  end

  // The core's reset is synchronous, so our async reset is passed straight
  // through to hold it cleared for as long as reset is asserted.
  assign bus.fir_rst  = reset | (state_q == ST_CLR);
  assign bus.fir_x    = fir_x_c;
  assign bus.s_ready  = s_ready_q;
  assign bus.busy     = busy_q;
  assign bus.underrun = underrun_q;
  assign bus.m_valid  = v2_q;
  assign bus.m_data   = bus.fir_y;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
module tb_fir_tap_sequencer;
  import fir_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fir_tap_sequencer_if bus();
  state_e dbg_state;

  fir_tap_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- FIR core model ----------------
  // Synchronous reset; after reset the first N_TAPS inputs shift into the
  // coefficient chain, later inputs shift into the data line. The output
  // register takes the sum of the current taps every cycle.
  logic signed [BW_IN-1:0] core_c [N_TAPS];
  logic signed [BW_IN-1:0] core_x [N_TAPS];
  logic [2:0]              core_ld;
  logic [BW_OUT-1:0]       core_sum;

  always_comb begin
    int acc;
    acc = 0;
    for (int k = 0; k < N_TAPS; k++) acc += int'(core_c[k]) * int'(core_x[k]);
    core_sum = BW_OUT'(acc);
  end

  always @(posedge clk) begin
    if (bus.fir_rst) begin
      for (int k = 0; k < N_TAPS; k++) begin
        core_c[k] <= '0;
        core_x[k] <= '0;
      end
      core_ld   <= '0;
      bus.fir_y <= '0;
    end else begin
      bus.fir_y <= core_sum;
      if (core_ld < 3'(N_TAPS)) begin
        core_c[0] <= bus.fir_x;
        for (int k = 1; k < N_TAPS; k++) core_c[k] <= core_c[k-1];
        core_ld <= core_ld + 3'd1;
      end else begin
        core_x[0] <= bus.fir_x;
        for (int k = 1; k < N_TAPS; k++) core_x[k] <= core_x[k-1];
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [BW_OUT-1:0]       exp_q[$];
  logic [BW_OUT-1:0]       exp_v;
  int                      n_checks = 0;
  int                      n_fail = 0;
  int                      n_beats = 0;
  logic signed [BW_IN-1:0] bank_m [N_TAPS];
  logic signed [BW_IN-1:0] hist   [N_TAPS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference filter: output = sum bank[k] * (k-th most recent fed sample).
  task automatic model_feed(input logic signed [BW_IN-1:0] smp);
    int acc;
    for (int k = N_TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = smp;
    acc = 0;
    for (int k = 0; k < N_TAPS; k++) acc += int'(bank_m[k]) * int'(hist[k]);
    exp_q.push_back(BW_OUT'(acc));
  endtask

  task automatic model_clear();
    for (int k = 0; k < N_TAPS; k++) hist[k] = '0;
  endtask

  always @(negedge clk) begin
    if (!reset && bus.m_valid === 1'b1) begin
      n_beats++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL unexpected_beat: got m_data %0h expected no beat", bus.m_data);
      end else begin
        exp_v = exp_q.pop_front();
        check($sformatf("m_data_beat%0d", n_beats), 32'(bus.m_data), 32'(exp_v));
      end
    end
  end

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic cfg_write(input logic [CNT_W-1:0] addr, input logic signed [BW_IN-1:0] data,
                           input logic taken);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    if (taken && int'(addr) < N_TAPS) bank_m[addr] = data;
  endtask

  task automatic set_bank(input logic signed [BW_IN-1:0] b0, input logic signed [BW_IN-1:0] b1,
                          input logic signed [BW_IN-1:0] b2, input logic signed [BW_IN-1:0] b3,
                          input logic signed [BW_IN-1:0] b4);
    cfg_write(3'd0, b0, 1'b1);
    cfg_write(3'd1, b1, 1'b1);
    cfg_write(3'd2, b2, 1'b1);
    cfg_write(3'd3, b3, 1'b1);
    cfg_write(3'd4, b4, 1'b1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    model_clear();
    check("clr_entered", 32'(dbg_state), 32'(ST_CLR));
    check("clr_fir_rst", 32'(bus.fir_rst), 32'd1);
    check("underrun_cleared_by_start", 32'(bus.underrun), 32'd0);
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (bus.s_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("run_entered_ready", 32'(bus.s_ready), 32'd1);
    check("clr_plus_load_cycles", 32'(t), 32'd6);
  endtask

  task automatic start_run();
    pulse_start();
    wait_ready();
  endtask

  task automatic feed(input logic v, input logic signed [BW_IN-1:0] d, input logic last);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.stop    = last;
    model_feed(v ? d : '0);
    @(negedge clk);
    if (last) begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.stop    = 1'b0;
      for (int k = 0; k < N_TAPS; k++) model_feed('0);
    end
  endtask

  task automatic finish_run();
    for (int i = 0; i < N_TAPS; i++) begin
      check("flush_state", 32'(dbg_state), 32'(ST_FLUSH));
      check("flush_not_ready", 32'(bus.s_ready), 32'd0);
      @(negedge clk);
    end
    check("idle_after_flush", 32'(dbg_state), 32'(ST_IDLE));
    check("busy_low_after_flush", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.start = 1'b0;  bus.stop = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      bank_m[k] = '0;
      hist[k]   = '0;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_fir_rst", 32'(bus.fir_rst), 32'd1);
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_fir_x", 32'(bus.fir_x), 32'd0);
    check("rst_underrun", 32'(bus.underrun), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_fir_rst", 32'(bus.fir_rst), 32'd0);

    // 1: identity bank, outputs 1,2,3,4 then flush zeros.
    set_bank(1, 0, 0, 0, 0);
    bus.stop = 1'b1;                 // stop in IDLE does nothing
    @(negedge clk);
    bus.stop = 1'b0;
    check("stop_ignored_in_idle", 32'(dbg_state), 32'(ST_IDLE));
    start_run();
    feed(1, 1, 0); feed(1, 2, 0); feed(1, 3, 0); feed(1, 4, 1);
    finish_run();
    check("t1_no_underrun", 32'(bus.underrun), 32'd0);

    // 2: moving sum, 1,3,6,10,15,20 then flush 18,15,11,6,0.
    set_bank(1, 1, 1, 1, 1);
    start_run();
    feed(1, 1, 0); feed(1, 2, 0); feed(1, 3, 0);
    feed(1, 4, 0); feed(1, 5, 0); feed(1, 6, 1);
    finish_run();

    // 3: impulse through {-1,2,0,0,3} gives -5,10,0,0,15; writes past the
    // last tap must not disturb the bank.
    set_bank(-1, 2, 0, 0, 3);
    cfg_write(3'd5, 6'sd9, 1'b0);
    cfg_write(3'd7, -6'sd3, 1'b0);
    start_run();
    feed(1, 5, 0); feed(1, 0, 0); feed(1, 0, 0); feed(1, 0, 0); feed(1, 0, 1);
    finish_run();

    // 4: a RUN cycle with s_valid low feeds a zero and sets the sticky flag.
    set_bank(1, 0, 0, 0, 0);
    start_run();
    feed(1, 7, 0);
    feed(0, 13, 0);
    check("underrun_set", 32'(bus.underrun), 32'd1);
    feed(1, 9, 1);
    finish_run();
    check("underrun_sticky", 32'(bus.underrun), 32'd1);

    // 5: reset in the middle of LOAD.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("t5_underrun_cleared", 32'(bus.underrun), 32'd0);
    repeat (2) @(negedge clk);
    check("t5_in_load", 32'(dbg_state), 32'(ST_LOAD));
    reset = 1'b1;
    #1;
    check("midload_rst_fir_rst", 32'(bus.fir_rst), 32'd1);
    check("midload_rst_busy", 32'(bus.busy), 32'd0);
    check("midload_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("midload_rst_fir_x", 32'(bus.fir_x), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < N_TAPS; k++) bank_m[k] = '0;
    @(negedge clk);
    set_bank(2, -1, 1, 0, 1);
    start_run();
    for (int i = 0; i < 6; i++) feed(1, BW_IN'($urandom_range(0, 63)), 1'b0);
    feed(1, BW_IN'($urandom_range(0, 63)), 1'b1);
    finish_run();

    // 6: cfg write and start during RUN are ignored.
    start_run();
    feed(1, BW_IN'($urandom_range(0, 63)), 1'b0);
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_data = 6'sd31;
    bus.start  = 1'b1;
    feed(1, BW_IN'($urandom_range(0, 63)), 1'b0);
    bus.cfg_we = 1'b0;
    bus.start  = 1'b0;
    check("start_ignored_in_run", 32'(dbg_state), 32'(ST_RUN));
    for (int i = 0; i < 3; i++) feed(1, BW_IN'($urandom_range(0, 63)), 1'b0);
    feed(1, BW_IN'($urandom_range(0, 63)), 1'b1);
    finish_run();

    // start and stop together in IDLE: start wins. The bank still holds the
    // values written before the ignored RUN-time write.
    bus.stop = 1'b1;
    start_run();
    for (int i = 0; i < 4; i++) feed(1, BW_IN'($urandom_range(0, 63)), 1'b0);
    feed(1, BW_IN'($urandom_range(0, 63)), 1'b1);
    finish_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
